spram_burst: RTL and testbench

- Parametrised single-port SRAM controller; successor to the fixed 32K x 32 bus-slave memory.
- Generic data width, depth and byte-lane write masks.
- Adds a post-reset clear sequencer and burst read/write commands with valid/ready handshakes and auto-incrementing, wrapping addresses.
- Sits between the eForth core / DMA masters and on-chip SPRAM.

---
 rtl/spram_burst_if.sv | 47 ++++
 rtl/spram_burst.sv | 158 +++++++++++++++
 tb/tb_spram_burst.sv | 409 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spram_burst_if.sv
// ---------------------------------------------------------------------------
// spram_burst_if
// Command, write-data and read-data bundle between a bus master (eForth core,
// DMA engine) and the spram_burst controller.
//
// Signals (named from the controller's side; _i = into controller):
//   req_i     command request, held by the master until accepted
//   rdy_o     controller can accept a command this cycle
//   we_i      1 = write burst, 0 = read burst
//   ai_i      burst start word address
//   len_i     burst length minus one
//   bmsk_i    byte-lane write enables for the burst
//   vi_i      write data
//   vi_v_i    write data valid
//   vi_rdy_o  controller is accepting write data
//   vo_o      read data (holds its last value between beats)
//   vo_v_o    read data valid
//   busy_o    controller is clearing or running a burst
// ---------------------------------------------------------------------------
interface spram_burst_if #(
    parameter int DSZ = 32,
    parameter int ASZ = 15,
    parameter int LSZ = 4
);
    logic               req_i;
    logic               rdy_o;
    logic               we_i;
    logic [ASZ-1:0]     ai_i;
    logic [LSZ-1:0]     len_i;
    logic [DSZ/8-1:0]   bmsk_i;
    logic [DSZ-1:0]     vi_i;
    logic               vi_v_i;
    logic               vi_rdy_o;
    logic [DSZ-1:0]     vo_o;
    logic               vo_v_o;
    logic               busy_o;

    modport master (
        output req_i, we_i, ai_i, len_i, bmsk_i, vi_i, vi_v_i,
        input  rdy_o, vi_rdy_o, vo_o, vo_v_o, busy_o
    );

    modport slave (
        input  req_i, we_i, ai_i, len_i, bmsk_i, vi_i, vi_v_i,
        output rdy_o, vi_rdy_o, vo_o, vo_v_o, busy_o
    );
endinterface

// File: rtl/spram_burst.sv
// ---------------------------------------------------------------------------
// spram_burst
// Parametrised single-port SRAM controller with byte-lane write masks, an
// optional post-reset clear sequencer and burst read/write commands whose
// word address auto-increments and wraps at the end of the array.
//
// Ports:
//   clk    system clock, all logic on the rising edge
//   rst_n  asynchronous active-low reset
//   bus    spram_burst_if slave modport (command, write data, read data)
//
// Parameters:
//   DSZ     data width in bits, multiple of 8
//   ASZ     word address width, array depth is 2**ASZ
//   LSZ     burst length field width, bursts are len+1 beats
//   CLR_EN  1 = zero the whole array after reset before accepting commands
// ---------------------------------------------------------------------------
module spram_burst #(
    parameter int DSZ    = 32,
    parameter int ASZ    = 15,
    parameter int LSZ    = 4,
    parameter bit CLR_EN = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    spram_burst_if.slave   bus
);

    localparam int NLANE = DSZ / 8;
    localparam int DEPTH = 2 ** ASZ;

    localparam logic [1:0] ST_CLR  = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_WR   = 2'd2;
    localparam logic [1:0] ST_RD   = 2'd3;

    localparam logic [1:0]     ST_RESET  = CLR_EN ? ST_CLR : ST_IDLE;
    localparam logic [ASZ-1:0] LAST_ADDR = '1;

    logic [1:0]       state_q, state_d;
    logic [ASZ-1:0]   addr_q, addr_d;
    logic [LSZ-1:0]   cnt_q, cnt_d;
    logic [NLANE-1:0] msk_q, msk_d;
    logic [DSZ-1:0]   vo_q, vo_d;
    logic             voValid_q, voValid_d;

    logic             memWe;
    logic [DSZ-1:0]   memWdata;
    logic [NLANE-1:0] memWmask;

    logic [DSZ-1:0]   mem [DEPTH];

    // Next-state logic. The same address register serves as the clear
    // pointer and the burst pointer; ASZ-bit arithmetic gives the wrap from
    // the last word back to word 0 for free. The count only decrements while
    // non-zero, so a maximum-length burst cannot underflow past zero.
    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        cnt_d     = cnt_q;
        msk_d     = msk_q;
        vo_d      = vo_q;
        voValid_d = 1'b0;
        memWe     = 1'b0;
        memWdata  = '0;
        memWmask  = '0;

        case (state_q)
            ST_CLR: begin
                memWe    = 1'b1;
                memWmask = '1;
                addr_d   = addr_q + ASZ'(1);
                if (addr_q == LAST_ADDR) begin
                    state_d = ST_IDLE;
                end
            end

            ST_IDLE: begin
                if (bus.req_i) begin
                    addr_d  = bus.ai_i;
                    cnt_d   = bus.len_i;
                    msk_d   = bus.bmsk_i;
                    state_d = bus.we_i ? ST_WR : ST_RD;
                end
            end

            ST_WR: begin
                if (bus.vi_v_i) begin
                    memWe    = 1'b1;
                    memWdata = bus.vi_i;
                    memWmask = msk_q;
                    addr_d   = addr_q + ASZ'(1);
                    if (cnt_q == '0) begin
                        state_d = ST_IDLE;
                    end else begin
                        cnt_d = cnt_q - LSZ'(1);
                    end
                end
            end

            ST_RD: begin
                vo_d      = mem[addr_q];
                voValid_d = 1'b1;
                addr_d    = addr_q + ASZ'(1);
                if (cnt_q == '0) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - LSZ'(1);
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Control and read-data registers. Reset abandons any burst on the spot
    // and restarts the clear from word 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_RESET;
            addr_q    <= '0;
            cnt_q     <= '0;
            msk_q     <= '0;
            vo_q      <= '0;
            voValid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            cnt_q     <= cnt_d;
            msk_q     <= msk_d;
            vo_q      <= vo_d;
            voValid_q <= voValid_d;
        end
    end

    // Storage array, no reset so it maps onto SPRAM. Lanes whose mask bit
    // is clear keep their previous contents.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int k = 0; k < NLANE; k++) begin
                if (memWmask[k]) begin
                    mem[addr_q][8*k +: 8] <= memWdata[8*k +: 8];
                end
            end
        end
    end

    // rdy is qualified with rst_n so that a build without the clear
    // sequence still refuses commands while reset is held.
    assign bus.rdy_o    = (state_q == ST_IDLE) && rst_n;
    assign bus.busy_o   = (state_q != ST_IDLE);
    assign bus.vi_rdy_o = (state_q == ST_WR);
    assign bus.vo_o     = vo_q;
    assign bus.vo_v_o   = voValid_q;

endmodule

// File: tb/tb_spram_burst.sv
// ---------------------------------------------------------------------------
// tb_spram_burst
// Self-checking bench for spram_burst (32-bit data, 32K words, 4-bit length
// field, clear enabled). Expected memory contents come from a word array
// updated with the byte-mask and wrapping-address rules.
// ---------------------------------------------------------------------------
module tb_spram_burst;
    localparam int DSZ   = 32;
    localparam int ASZ   = 15;
    localparam int LSZ   = 4;
    localparam int NLANE = DSZ / 8;
    localparam int DEPTH = 1 << ASZ;

    logic clk;
    logic rst_n = 1'b0;

    int vectors;
    int miscompares;

    logic [DSZ-1:0] model [DEPTH];
    logic [DSZ-1:0] wrData [$];
    logic [DSZ-1:0] rdData [$];
    logic [31:0]    rdPat;

    spram_burst_if #(.DSZ(DSZ), .ASZ(ASZ), .LSZ(LSZ)) bus ();

    spram_burst #(
        .DSZ(DSZ), .ASZ(ASZ), .LSZ(LSZ), .CLR_EN(1'b1)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock and settle just after the rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clearModel();
        for (int i = 0; i < DEPTH; i++) model[i] = '0;
    endtask

    // Expected vo_v samples: idle on the acceptance cycle, then len+1 beats.
    function automatic logic [31:0] expPattern(input int len);
        return ((32'd1 << (len + 1)) - 32'd1) << 1;
    endfunction

    function automatic int wrapAddr(input logic [ASZ-1:0] base, input int i);
        return (int'(base) + i) % DEPTH;
    endfunction

    task automatic waitReady(output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            if (bus.rdy_o === 1'b1) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
    endtask

    // Write wrData[0..len]; gap idle cycles between beats (negative = random).
    task automatic applyWrite(input logic [ASZ-1:0] addr, input logic [LSZ-1:0] len,
                              input logic [NLANE-1:0] mask, input int gap,
                              output bit ok, output bit rdyAfter);
        int a;
        int g;
        rdyAfter = 1'b0;
        waitReady(ok);
        if (!ok) return;
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b1;
        bus.ai_i   = addr;
        bus.len_i  = len;
        bus.bmsk_i = mask;
        tick();
        bus.req_i = 1'b0;
        bus.ai_i  = ASZ'($urandom);
        bus.len_i = LSZ'($urandom);
        for (int i = 0; i <= int'(len); i++) begin
            if (i > 0) begin
                g = (gap < 0) ? int'($urandom_range(0, 2)) : gap;
                for (int s = 0; s < g; s++) begin
                    bus.vi_v_i = 1'b0;
                    bus.vi_i   = DSZ'($urandom);
                    tick();
                end
            end
            bus.vi_v_i = 1'b1;
            bus.vi_i   = wrData[i];
            tick();
        end
        bus.vi_v_i = 1'b0;
        rdyAfter   = bus.rdy_o;
        for (int i = 0; i <= int'(len); i++) begin
            a = wrapAddr(addr, i);
            for (int k = 0; k < NLANE; k++) begin
                if (mask[k]) model[a][8*k +: 8] = wrData[i][8*k +: 8];
            end
        end
    endtask

    // Issue a read burst and record vo_v per cycle plus every valid word.
    task automatic applyRead(input logic [ASZ-1:0] addr, input logic [LSZ-1:0] len,
                             output bit ok);
        rdData.delete();
        rdPat = '0;
        waitReady(ok);
        if (!ok) return;
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.ai_i   = addr;
        bus.len_i  = len;
        bus.bmsk_i = NLANE'($urandom);
        tick();
        bus.req_i = 1'b0;
        for (int j = 0; j <= int'(len) + 2; j++) begin
            rdPat[j] = bus.vo_v_o;
            if (bus.vo_v_o === 1'b1) rdData.push_back(bus.vo_o);
            tick();
        end
    endtask

    task automatic test_reset();
        tick();
        tick();
        vectors++;
        if (bus.busy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL reset_busy: got %b expected 1", bus.busy_o); end
        vectors++;
        if (bus.rdy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_rdy: got %b expected 0", bus.rdy_o); end
        vectors++;
        if (bus.vi_rdy_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vi_rdy: got %b expected 0", bus.vi_rdy_o); end
        vectors++;
        if (bus.vo_v_o !== 1'b0) begin miscompares++; $display("[TB] FAIL reset_vo_v: got %b expected 0", bus.vo_v_o); end
        vectors++;
        if (bus.vo_o !== '0) begin miscompares++; $display("[TB] FAIL reset_vo: got %h expected 0", bus.vo_o); end
    endtask

    task automatic test_clear();
        int n;
        bit ok;
        logic [ASZ-1:0] addrs [3];
        logic [LSZ-1:0] lens [3];
        addrs[0] = 15'h0000; lens[0] = 4'hF;
        addrs[1] = 15'h4000; lens[1] = LSZ'($urandom);
        addrs[2] = 15'h7FFF; lens[2] = 4'hF;
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.busy_o === 1'b1 && n < DEPTH + 64) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DEPTH) begin miscompares++; $display("[TB] FAIL clear_cycles: got %0d expected %0d", n, DEPTH); end
        vectors++;
        if (bus.rdy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL clear_rdy: got %b expected 1", bus.rdy_o); end
        clearModel();
        for (int r = 0; r < 3; r++) begin
            applyRead(addrs[r], lens[r], ok);
            vectors++;
            if (!ok) begin miscompares++; $display("[TB] FAIL clear_read_accept: got timeout expected rdy"); end
            vectors++;
            if (rdPat !== expPattern(int'(lens[r]))) begin
                miscompares++; $display("[TB] FAIL clear_vo_v: got %b expected %b", rdPat, expPattern(int'(lens[r])));
            end
            for (int i = 0; i <= int'(lens[r]); i++) begin
                vectors++;
                if (i >= rdData.size() || rdData[i] !== model[wrapAddr(addrs[r], i)]) begin
                    miscompares++;
                    $display("[TB] FAIL clear_word @%h: got %h expected %h", wrapAddr(addrs[r], i),
                             (i < rdData.size()) ? rdData[i] : 'x, model[wrapAddr(addrs[r], i)]);
                end
            end
        end
    endtask

    task automatic test_byte_mask();
        bit ok;
        bit ra;
        wrData = '{32'hFFFF_FFFF};
        applyWrite(15'h0010, 4'd0, 4'b1111, 0, ok, ra);
        vectors++;
        if (!(ok && ra)) begin miscompares++; $display("[TB] FAIL mask_wr1_handshake: got ok=%b rdy=%b expected 1 1", ok, ra); end
        wrData = '{32'h1234_5678};
        applyWrite(15'h0010, 4'd0, 4'b0101, 0, ok, ra);
        vectors++;
        if (!(ok && ra)) begin miscompares++; $display("[TB] FAIL mask_wr2_handshake: got ok=%b rdy=%b expected 1 1", ok, ra); end
        applyRead(15'h0010, 4'd0, ok);
        vectors++;
        if (rdPat !== 32'b010) begin miscompares++; $display("[TB] FAIL mask_vo_v: got %b expected 010", rdPat); end
        vectors++;
        if (rdData.size() < 1 || rdData[0] !== 32'hFF34_FF78) begin
            miscompares++;
            $display("[TB] FAIL mask_word: got %h expected ff34ff78", (rdData.size() > 0) ? rdData[0] : 'x);
        end
    endtask

    task automatic test_wrap();
        bit ok;
        bit ra;
        wrData = '{32'd1, 32'd2, 32'd3, 32'd4};
        applyWrite(15'h7FFE, 4'd3, 4'b1111, 0, ok, ra);
        vectors++;
        if (!(ok && ra)) begin miscompares++; $display("[TB] FAIL wrap_wr_handshake: got ok=%b rdy=%b expected 1 1", ok, ra); end
        applyRead(15'h7FFE, 4'd3, ok);
        vectors++;
        if (rdPat !== 32'b11110) begin miscompares++; $display("[TB] FAIL wrap_vo_v: got %b expected 11110", rdPat); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= rdData.size() || rdData[i] !== DSZ'(i + 1)) begin
                miscompares++;
                $display("[TB] FAIL wrap_word %0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 'x, i + 1);
            end
        end
    endtask

    task automatic test_stall();
        bit ok;
        bit ra;
        wrData = '{DSZ'($urandom), DSZ'($urandom), DSZ'($urandom)};
        applyWrite(15'h0100, 4'd2, 4'b1111, 1, ok, ra);
        vectors++;
        if (!(ok && ra)) begin miscompares++; $display("[TB] FAIL stall_handshake: got ok=%b rdy=%b expected 1 1", ok, ra); end
        applyRead(15'h0100, 4'd3, ok);
        vectors++;
        if (rdPat !== expPattern(3)) begin miscompares++; $display("[TB] FAIL stall_vo_v: got %b expected %b", rdPat, expPattern(3)); end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (i >= rdData.size() || rdData[i] !== model[16'h0100 + i]) begin
                miscompares++;
                $display("[TB] FAIL stall_word %0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 'x, model[16'h0100 + i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        bit ok;
        bit ra;
        wrData = '{DSZ'($urandom), DSZ'($urandom)};
        applyWrite(15'h0010, 4'd1, 4'b1111, -1, ok, ra);
        waitReady(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL b2b_accept: got timeout expected rdy"); end
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b0;
        bus.ai_i   = 15'h0010;
        bus.len_i  = 4'd0;
        tick();
        bus.ai_i = 15'h0011;
        tick();
        vectors++;
        if (bus.vo_v_o !== 1'b1 || bus.vo_o !== model[16'h0010]) begin
            miscompares++; $display("[TB] FAIL b2b_beat1: got v=%b d=%h expected v=1 d=%h", bus.vo_v_o, bus.vo_o, model[16'h0010]);
        end
        vectors++;
        if (bus.rdy_o !== 1'b1) begin miscompares++; $display("[TB] FAIL b2b_rdy: got %b expected 1", bus.rdy_o); end
        tick();
        bus.req_i = 1'b0;
        vectors++;
        if (bus.vo_v_o !== 1'b0 || bus.vo_o !== model[16'h0010]) begin
            miscompares++; $display("[TB] FAIL b2b_gap: got v=%b d=%h expected v=0 d=%h", bus.vo_v_o, bus.vo_o, model[16'h0010]);
        end
        tick();
        vectors++;
        if (bus.vo_v_o !== 1'b1 || bus.vo_o !== model[16'h0011]) begin
            miscompares++; $display("[TB] FAIL b2b_beat2: got v=%b d=%h expected v=1 d=%h", bus.vo_v_o, bus.vo_o, model[16'h0011]);
        end
        tick();
        vectors++;
        if (bus.vo_v_o !== 1'b0 || bus.rdy_o !== 1'b1) begin
            miscompares++; $display("[TB] FAIL b2b_end: got v=%b rdy=%b expected v=0 rdy=1", bus.vo_v_o, bus.rdy_o);
        end
    endtask

    task automatic test_random();
        bit ok;
        bit ra;
        logic [ASZ-1:0]   addr;
        logic [ASZ-1:0]   raddr;
        logic [LSZ-1:0]   len;
        logic [LSZ-1:0]   rlen;
        logic [NLANE-1:0] mask;
        for (int it = 0; it < 10; it++) begin
            addr = (it % 3 == 0) ? ASZ'(DEPTH - int'($urandom_range(1, 8))) : ASZ'($urandom_range(0, 255));
            len  = (it == 0) ? 4'hF : LSZ'($urandom);
            mask = (it == 1) ? 4'b0000 : NLANE'($urandom);
            wrData.delete();
            for (int i = 0; i <= int'(len); i++) wrData.push_back(DSZ'($urandom));
            bus.vi_v_i = 1'b1;
            bus.vi_i   = DSZ'($urandom);
            tick();
            tick();
            bus.vi_v_i = 1'b0;
            applyWrite(addr, len, mask, -1, ok, ra);
            vectors++;
            if (!(ok && ra)) begin miscompares++; $display("[TB] FAIL rand_wr_handshake %0d: got ok=%b rdy=%b expected 1 1", it, ok, ra); end
            raddr = addr - ASZ'($urandom_range(0, 3));
            rlen  = LSZ'($urandom);
            applyRead(raddr, rlen, ok);
            vectors++;
            if (rdPat !== expPattern(int'(rlen))) begin
                miscompares++; $display("[TB] FAIL rand_vo_v %0d: got %b expected %b", it, rdPat, expPattern(int'(rlen)));
            end
            for (int i = 0; i <= int'(rlen); i++) begin
                vectors++;
                if (i >= rdData.size() || rdData[i] !== model[wrapAddr(raddr, i)]) begin
                    miscompares++;
                    $display("[TB] FAIL rand_word @%h: got %h expected %h", wrapAddr(raddr, i),
                             (i < rdData.size()) ? rdData[i] : 'x, model[wrapAddr(raddr, i)]);
                end
            end
        end
    endtask

    task automatic test_reset_midop();
        bit ok;
        int n;
        wrData.delete();
        for (int i = 0; i < 8; i++) wrData.push_back(DSZ'($urandom) | 32'h1);
        waitReady(ok);
        vectors++;
        if (!ok) begin miscompares++; $display("[TB] FAIL midop_accept: got timeout expected rdy"); end
        bus.req_i  = 1'b1;
        bus.we_i   = 1'b1;
        bus.ai_i   = 15'h0020;
        bus.len_i  = 4'd7;
        bus.bmsk_i = 4'b1111;
        tick();
        bus.req_i  = 1'b0;
        bus.vi_v_i = 1'b1;
        bus.vi_i   = wrData[0];
        tick();
        bus.vi_i   = wrData[1];
        tick();
        bus.vi_i   = wrData[2];
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        vectors++;
        if (bus.rdy_o !== 1'b0 || bus.vo_v_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midop_outputs: got rdy=%b vo_v=%b expected 0 0", bus.rdy_o, bus.vo_v_o);
        end
        vectors++;
        if (bus.busy_o !== 1'b1 || bus.vi_rdy_o !== 1'b0) begin
            miscompares++; $display("[TB] FAIL midop_state: got busy=%b vi_rdy=%b expected 1 0", bus.busy_o, bus.vi_rdy_o);
        end
        bus.vi_v_i = 1'b0;
        tick();
        tick();
        @(negedge clk);
        rst_n = 1'b1;
        n = 0;
        while (bus.busy_o === 1'b1 && n < DEPTH + 64) begin
            tick();
            n++;
        end
        vectors++;
        if (n != DEPTH) begin miscompares++; $display("[TB] FAIL midop_clear_cycles: got %0d expected %0d", n, DEPTH); end
        clearModel();
        applyRead(15'h0020, 4'd7, ok);
        vectors++;
        if (rdPat !== expPattern(7)) begin miscompares++; $display("[TB] FAIL midop_vo_v: got %b expected %b", rdPat, expPattern(7)); end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (i >= rdData.size() || rdData[i] !== model[16'h0020 + i]) begin
                miscompares++;
                $display("[TB] FAIL midop_word %0d: got %h expected %h", i, (i < rdData.size()) ? rdData[i] : 'x, model[16'h0020 + i]);
            end
        end
    endtask

    // Sequence every scenario and print the one-line summary.
    initial begin
        vectors     = 0;
        miscompares = 0;
        bus.req_i   = 1'b0;
        bus.we_i    = 1'b0;
        bus.ai_i    = '0;
        bus.len_i   = '0;
        bus.bmsk_i  = '0;
        bus.vi_i    = '0;
        bus.vi_v_i  = 1'b0;
        test_reset();
        test_clear();
        test_byte_mask();
        test_wrap();
        test_stall();
        test_back_to_back();
        test_random();
        test_reset_midop();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    // Guard against a hung design.
    initial begin
        #5_000_000;
        $display("[TB] FAIL watchdog: got no finish expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
